fixed_to_floating_point_converter: RTL and testbench

Converts a signed two's-complement fixed-point sample into the team's packed floating-point word {sign, exponent, mantissa with hidden 1}. This is the same format consumed by floating_point_comparator and the PWL sigmoid/tanh datapath. The block sits at the float-producing end of that interface: fixed-point results from the PWL evaluators re-enter the float domain here. Normalization is iterative, one left shift per cycle, behind a valid/ready handshake on each side.

---
 rtl/fixed_to_floating_point_converter.sv | 131 +++++++++++++
 tb/tb_fixed_to_floating_point_converter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fixed_to_floating_point_converter.sv
// fixed_to_floating_point_converter
//   Converts a signed two's-complement fixed-point sample (value = in_data / 2^FRAC)
//   into the packed float word {sign, exp[E-1:0], man[M-1:0]} with a hidden leading 1.
//   Normalization shifts the magnitude left one bit per cycle until its MSB is set.
//   Mantissa bits below the kept field are truncated (round toward zero).
//   Underflow flushes to zero and overflow saturates to the all-ones exp/man.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_data   in   [IN_WIDTH-1:0]   signed fixed-point operand
//   in_valid  in   operand valid
//   in_ready  out  block can accept an operand (only in IDLE)
//   out_data  out  [DATA_WIDTH-1:0] float result, held stable while out_valid
//   out_valid out  result valid
//   out_ready in   downstream accepts result
module fixed_to_floating_point_converter #(
    parameter int DATA_WIDTH = 10,
    parameter int M          = 5,
    parameter int E          = 4,
    parameter int BIAS       = 7,
    parameter int IN_WIDTH   = 12,
    parameter int FRAC       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int EXP_W = E + $clog2(IN_WIDTH) + 1;

    // Exponent of a magnitude whose MSB is already set; each normalizing shift subtracts one.
    localparam logic signed [EXP_W-1:0] EXP_INIT = EXP_W'(IN_WIDTH - 1 - FRAC + BIAS);
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'((1 << E) - 1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t                   r_state;
    logic                     r_sign;
    logic [IN_WIDTH-1:0]      r_mag;
    logic signed [EXP_W-1:0]  r_exp;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic                     r_in_ready;

    state_t                   w_state_nxt;
    logic                     w_sign_nxt;
    logic [IN_WIDTH-1:0]      w_mag_nxt;
    logic signed [EXP_W-1:0]  w_exp_nxt;
    logic [DATA_WIDTH-1:0]    w_out_nxt;
    logic [IN_WIDTH-1:0]      w_abs;
    logic [DATA_WIDTH-1:0]    w_result;

    // The most negative input negates to 2^(IN_WIDTH-1), which still fits as unsigned.
    assign w_abs = in_data[IN_WIDTH-1] ? (~in_data + 1'b1) : in_data;

    always_comb begin
        w_result = '0;
        if (r_exp[EXP_W-1]) begin
            w_result = '0;
        end else if (r_exp > EXP_MAX) begin
            w_result = {r_sign, {E{1'b1}}, {M{1'b1}}};
        end else begin
            w_result = {r_sign, r_exp[E-1:0], r_mag[IN_WIDTH-2 -: M]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_mag_nxt   = r_mag;
        w_exp_nxt   = r_exp;
        w_out_nxt   = r_out_data;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_sign_nxt  = in_data[IN_WIDTH-1];
                    w_mag_nxt   = w_abs;
                    w_exp_nxt   = EXP_INIT;
                    w_state_nxt = NORM;
                end
            end
            NORM: begin
                if (r_mag == '0) begin
                    w_out_nxt   = '0;
                    w_state_nxt = DONE;
                end else if (r_mag[IN_WIDTH-1]) begin
                    w_out_nxt   = w_result;
                    w_state_nxt = DONE;
                end else begin
                    w_mag_nxt = r_mag << 1;
                    w_exp_nxt = r_exp - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_exp      <= '0;
            r_out_data <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sign     <= w_sign_nxt;
            r_mag      <= w_mag_nxt;
            r_exp      <= w_exp_nxt;
            r_out_data <= w_out_nxt;
            // Registered so ready stays low through reset and rises the cycle after.
            r_in_ready <= (w_state_nxt == IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_fixed_to_floating_point_converter.sv
// Directed-vector bench for fixed_to_floating_point_converter.
// A second instance with BIAS=14 covers exponent saturation.
module tb_fixed_to_floating_point_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [9:0]  out_data;
    logic        in_ready2, out_valid2;
    logic [9:0]  out_data2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fixed_to_floating_point_converter dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    fixed_to_floating_point_converter #(.BIAS(14)) dut_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offers one operand, measures cycles from the accept cycle T to first out_valid,
    // optionally stalls the output for `hold` cycles, then completes the handshake.
    task automatic convert(input string tag, input logic [11:0] d, input logic [9:0] exp,
                           input int lat_exp, input int hold);
        int lat;
        logic [9:0] first;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        first = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(first));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        convert("pos1p0",  12'h100, 10'h0E0, 5, 0);
        convert("neg1p5",  12'hE80, 10'h2F0, 5, 0);
        convert("trunc",   12'h1FF, 10'h0FF, 5, 0);
        convert("neg8",    12'h800, 10'h340, 2, 0);
        check("sat_bias14", 32'(out_data2), 32'h3FF);
        convert("zero",    12'h000, 10'h000, 2, 0);
        convert("uflow",   12'h001, 10'h000, 13, 0);
        convert("bp",      12'h100, 10'h0E0, 5, 5);
        convert("bp_next", 12'hE80, 10'h2F0, 5, 0);

        // Reset while normalizing: the abandoned operand must never produce a result.
        @(negedge clk);
        in_data  = 12'h001;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        convert("after_rst", 12'h100, 10'h0E0, 5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
